// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Requester index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam logic [31:0] LED_OFF = '0;

endpackage

// File: rtl/led_bank_arbiter_rr_picker.sv
// Combinational round-robin search: first req set at ptr+1, ptr+2, ... modulo N_REQ.
module rr_picker
    import led_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int k = int'(N_REQ); k > 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % int'(N_REQ));
            if (req_i[cand]) begin
                winner_o = cand;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin req/grant arbiter sharing one LED bank, with a one-cycle blank gap between owners.
// Optional preemption after MAX_HOLD cycles is enabled by defining LED_ARB_TIMEOUT_EN.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned LED_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LED_W-1:0] led_in,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [LED_W-1:0]       led
);

    localparam int unsigned      IDX_W   = idx_width(N_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
        $error("led_bank_arbiter: N_REQ must be 2..4");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("led_bank_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [LED_W-1:0] led_slice [N_REQ];

`ifdef LED_ARB_TIMEOUT_EN
    localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_slice
        assign led_slice[i] = led_in[i*LED_W +: LED_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // Next-state and next-output logic; ptr_q doubles as the owner index while in OWN.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        led_d   = (|grant_q) ? led_slice[ptr_q] : LED_W'(LED_OFF);
`ifdef LED_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = N_REQ'(1) << pick_idx;
                    ptr_d   = pick_idx;
                    state_d = OWN;
`ifdef LED_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            OWN: begin
                if (!req[ptr_q]) begin
                    grant_d = '0;
                    state_d = GAP;
                end
`ifdef LED_ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_LAST && |(req & ~grant_q)) begin
                    grant_d = '0;
                    state_d = GAP;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
            GAP:     state_d = IDLE;
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            led_q   <= LED_W'(LED_OFF);
`ifdef LED_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            led_q   <= led_d;
`ifdef LED_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = |grant_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scenario bench for led_bank_arbiter (N_REQ=2, LED_W=3, MAX_HOLD=4); expected outputs go through a queue.
module tb_led_bank_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 3;
    localparam int unsigned MH = 4;

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic [1:0] g;
        logic [2:0] l;
    } row_t;

    typedef struct packed {
        logic [1:0] grant;
        logic [2:0] led;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] led_in;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   led;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    led_bank_arbiter #(
        .N_REQ    (N),
        .LED_W    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .led_in (led_in),
        .grant  (grant),
        .busy   (busy),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held 2 cycles with both requesting; requester 0 wins first afterwards.
    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        led_in = {3'b110, 3'b011};
        rows = '{'{1'b1, 2'b11, 2'b00, 3'b000}, '{1'b1, 2'b11, 2'b00, 3'b000},
                 '{1'b0, 2'b11, 2'b01, 3'b000}, '{1'b0, 2'b11, 2'b01, 3'b011},
                 '{1'b0, 2'b00, 2'b00, 3'b011}, '{1'b0, 2'b00, 2'b00, 3'b000},
                 '{1'b0, 2'b00, 2'b00, 3'b000}};
        foreach (rows[i]) begin
            rst = rows[i].rst;
            req = rows[i].req;
            exp_q.push_back('{rows[i].g, rows[i].l});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL reset.grant cyc %0d: got %b want %b", i, grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL reset.led cyc %0d: got %b want %b", i, led, e.led); end
            n_cmp++;
            if (busy !== |e.grant) begin n_err++; $display("FAIL reset.busy cyc %0d: got %b want %b", i, busy, |e.grant); end
        end
    endtask

    // Lone requester 0: grant one edge after req, led one edge later, blank after release.
    task automatic test_single();
        row_t rows[$];
        exp_t e;
        led_in = {3'b000, 3'b101};
        rows = '{'{1'b0, 2'b01, 2'b01, 3'b000}, '{1'b0, 2'b01, 2'b01, 3'b101},
                 '{1'b0, 2'b01, 2'b01, 3'b101}, '{1'b0, 2'b01, 2'b01, 3'b101},
                 '{1'b0, 2'b00, 2'b00, 3'b101}, '{1'b0, 2'b00, 2'b00, 3'b000},
                 '{1'b0, 2'b00, 2'b00, 3'b000}};
        foreach (rows[i]) begin
            req = rows[i].req;
            exp_q.push_back('{rows[i].g, rows[i].l});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL single.grant cyc %0d: got %b want %b", i, grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL single.led cyc %0d: got %b want %b", i, led, e.led); end
            n_cmp++;
            if (busy !== |e.grant) begin n_err++; $display("FAIL single.busy cyc %0d: got %b want %b", i, busy, |e.grant); end
        end
    endtask

    // Requester 1 scrambles its pattern every cycle while requester 0 owns the bank.
    task automatic test_isolation();
        row_t rows[$];
        exp_t e;
        rows = '{'{1'b0, 2'b01, 2'b01, 3'b000}};
        for (int k = 0; k < 8; k++) rows.push_back('{1'b0, 2'b01, 2'b01, 3'b110});
        rows.push_back('{1'b0, 2'b00, 2'b00, 3'b110});
        rows.push_back('{1'b0, 2'b00, 2'b00, 3'b000});
        rows.push_back('{1'b0, 2'b00, 2'b00, 3'b000});
        foreach (rows[i]) begin
            req         = rows[i].req;
            led_in[2:0] = 3'b110;
            led_in[5:3] = 3'($urandom);
            exp_q.push_back('{rows[i].g, rows[i].l});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL isolation.grant cyc %0d: got %b want %b", i, grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL isolation.led cyc %0d: got %b want %b", i, led, e.led); end
        end
    endtask

    // Reset while requester 1 owns: bank blanks next edge and requester 0 wins next.
    task automatic test_mid_reset();
        row_t rows[$];
        exp_t e;
        led_in = {3'b110, 3'b001};
        rows = '{'{1'b0, 2'b10, 2'b10, 3'b000}, '{1'b0, 2'b10, 2'b10, 3'b110},
                 '{1'b0, 2'b10, 2'b10, 3'b110}, '{1'b1, 2'b11, 2'b00, 3'b000},
                 '{1'b0, 2'b11, 2'b01, 3'b000}, '{1'b0, 2'b11, 2'b01, 3'b001},
                 '{1'b0, 2'b00, 2'b00, 3'b001}, '{1'b0, 2'b00, 2'b00, 3'b000},
                 '{1'b0, 2'b00, 2'b00, 3'b000}};
        foreach (rows[i]) begin
            rst = rows[i].rst;
            req = rows[i].req;
            exp_q.push_back('{rows[i].g, rows[i].l});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL mid_reset.grant cyc %0d: got %b want %b", i, grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL mid_reset.led cyc %0d: got %b want %b", i, led, e.led); end
        end
        rst = 1'b0;
    endtask

    // Owner hands over in the same cycle the other requester rises: GAP then IDLE before the new grant.
    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        led_in = {3'b010, 3'b111};
        rows = '{'{1'b0, 2'b01, 2'b01, 3'b000}, '{1'b0, 2'b01, 2'b01, 3'b111},
                 '{1'b0, 2'b10, 2'b00, 3'b111}, '{1'b0, 2'b10, 2'b00, 3'b000},
                 '{1'b0, 2'b10, 2'b10, 3'b000}, '{1'b0, 2'b10, 2'b10, 3'b010},
                 '{1'b0, 2'b00, 2'b00, 3'b010}, '{1'b0, 2'b00, 2'b00, 3'b000},
                 '{1'b0, 2'b00, 2'b00, 3'b000}};
        foreach (rows[i]) begin
            req = rows[i].req;
            exp_q.push_back('{rows[i].g, rows[i].l});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL back_to_back.grant cyc %0d: got %b want %b", i, grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL back_to_back.led cyc %0d: got %b want %b", i, led, e.led); end
        end
    endtask

`ifdef LED_ARB_TIMEOUT_EN
    // Both requesting: each owner is preempted after exactly MH cycles.
    task automatic test_round_robin();
        logic [1:0] eg[$];
        logic [2:0] el[$];
        exp_t e;
        led_in = {3'b100, 3'b011};
        eg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
        el = '{3'b000, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000,
               3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b011};
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b11;
        foreach (eg[i]) exp_q.push_back('{eg[i], el[i]});
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL round_robin.grant cyc %0d: got %b want %b", 13 - exp_q.size(), grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL round_robin.led cyc %0d: got %b want %b", 13 - exp_q.size(), led, e.led); end
        end
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (grant !== 2'b00 || led !== 3'b000) begin n_err++; $display("FAIL round_robin.drain: got %b/%b want 00/000", grant, led); end
    endtask
`else
    // Both requesting without preemption: requester 0 keeps the bank.
    task automatic test_no_timeout();
        exp_t e;
        led_in = {3'b100, 3'b011};
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b11;
        exp_q.push_back('{2'b01, 3'b000});
        for (int k = 0; k < 3 * int'(MH) + 4; k++) exp_q.push_back('{2'b01, 3'b011});
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant) begin n_err++; $display("FAIL no_timeout.grant left %0d: got %b want %b", exp_q.size(), grant, e.grant); end
            n_cmp++;
            if (led !== e.led) begin n_err++; $display("FAIL no_timeout.led left %0d: got %b want %b", exp_q.size(), led, e.led); end
        end
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (grant !== 2'b00 || led !== 3'b000) begin n_err++; $display("FAIL no_timeout.drain: got %b/%b want 00/000", grant, led); end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        req    = '0;
        led_in = '0;
        test_reset();
        test_single();
        test_isolation();
        test_mid_reset();
        test_back_to_back();
`ifdef LED_ARB_TIMEOUT_EN
        test_round_robin();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
